// File: rtl/my_or16.sv
// my_or16: word-wide bitwise OR assembled from 2-input NAND gates, plus an OR-tree
// "any bit set" flag and a one-cycle registered copy qualified by a valid strobe.
module my_or16 #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_Q,
  output logic             OUT_VALID,
  output logic             OUT_ANY
);

  wire [WIDTH-1:0]   a_n_s;
  wire [WIDTH-1:0]   b_n_s;
  wire [WIDTH-1:0]   or_s;
  wire [2*WIDTH-2:0] tree_s;

  logic [WIDTH-1:0] out_q_d;
  logic [WIDTH-1:0] out_q_q;
  logic             out_valid_d;
  logic             out_valid_q;

  // Per-bit OR as NAND(NAND(a,a), NAND(b,b)): invert each operand, then NAND.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand u_nand_a (a_n_s[i], A[i], A[i]);
    nand u_nand_b (b_n_s[i], B[i], B[i]);
    nand u_nand_o (or_s[i], a_n_s[i], b_n_s[i]);
  end

  // Heap-ordered reduction: leaves occupy [WIDTH-1:0], node WIDTH+k merges
  // nodes 2k and 2k+1, and the root lands on the top index.
  assign tree_s[WIDTH-1:0] = or_s;
  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_tree
    or u_or2 (tree_s[WIDTH+k], tree_s[2*k], tree_s[2*k+1]);
  end

  assign OUT     = or_s;
  assign OUT_ANY = tree_s[2*WIDTH-2];

  // Next-state for the capture stage: load on strobe, otherwise hold data and drop valid.
  always_comb begin
    out_q_d     = out_q_q;
    out_valid_d = 1'b0;
    if (IN_VALID) begin
      out_q_d     = or_s;
      out_valid_d = 1'b1;
    end else begin
      out_q_d     = out_q_q;
      out_valid_d = 1'b0;
    end
  end

  // Capture flops; reset clears both data and valid without waiting for a clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q_q     <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_Q     = out_q_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_my_or16.sv
// Self-checking bench for my_or16: a reference model checked every falling edge,
// plus directed vectors with hand-computed expectations.
module tb_my_or16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_valid = 1'b0;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;
  logic        out_any;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl_q;
  logic        mdl_v;

  my_or16 #(.WIDTH(16)) dut (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .IN_VALID(in_valid),
    .OUT(out), .OUT_Q(out_q), .OUT_VALID(out_valid), .OUT_ANY(out_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t, a=%h b=%h)", name, act, exp, $time, a, b);
    end
  endtask

  // Reference model of the registered stage: what was captured last, and whether it was last cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_q <= 16'h0000;
      mdl_v <= 1'b0;
    end else begin
      mdl_v <= in_valid;
      if (in_valid) mdl_q <= a | b;
    end
  end

  // Continuous compare on every falling edge.
  always @(negedge clk) begin
    chk("out_cont", out, a | b);
    chk("any_cont", {15'd0, out_any}, {15'd0, (a | b) != 16'h0000});
    chk("q_cont", out_q, mdl_q);
    chk("valid_cont", {15'd0, out_valid}, {15'd0, mdl_v});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spot(input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] e_out, input logic e_any, input string name);
    a = va;
    b = vb;
    #1;
    chk(name, out, e_out);
    chk({name, "_any"}, {15'd0, out_any}, {15'd0, e_any});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset_q", out_q, 16'h0000);
    chk("reset_valid", {15'd0, out_valid}, 16'h0000);
    rst_n = 1'b1;

    spot(16'h0000, 16'h0000, 16'h0000, 1'b0, "spot_zero");
    spot(16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, "spot_ones");
    spot(16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, "spot_alt");
    spot(16'h8000, 16'h0000, 16'h8000, 1'b1, "any_msb");
    spot(16'h0000, 16'h0001, 16'h0001, 1'b1, "any_lsb");
    spot(16'hC3C3, 16'h0F0F, 16'hCFCF, 1'b1, "spot_mix");

    // Every single bit on either operand must reach OUT and OUT_ANY.
    for (int i = 0; i < 16; i++) begin
      spot(16'h0001 << i, 16'h0000, 16'h0001 << i, 1'b1, "walk_a");
      spot(16'h0000, 16'h8000 >> i, 16'h8000 >> i, 1'b1, "walk_b");
    end

    // Single capture, then hold.
    step();
    a = 16'h00F0; b = 16'h0F00; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = 16'h1111; b = 16'h0000;
    chk("cap_q", out_q, 16'h0FF0);
    chk("cap_valid", {15'd0, out_valid}, 16'h0001);
    step();
    chk("hold_q", out_q, 16'h0FF0);
    chk("hold_valid", {15'd0, out_valid}, 16'h0000);

    // Back-to-back captures.
    a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    step();
    a = 16'h1000; b = 16'h0100;
    chk("b2b_q0", out_q, 16'h0003);
    chk("b2b_v0", {15'd0, out_valid}, 16'h0001);
    step();
    in_valid = 1'b0;
    chk("b2b_q1", out_q, 16'h1100);
    chk("b2b_v1", {15'd0, out_valid}, 16'h0001);

    // Asynchronous reset mid-stream with OUT_Q = FFFF.
    a = 16'hFFFF; b = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre_rst_q", out_q, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", out_q, 16'h0000);
    chk("async_valid", {15'd0, out_valid}, 16'h0000);
    spot(16'h0F0F, 16'h3000, 16'h3F0F, 1'b1, "out_in_reset");
    in_valid = 1'b1;
    step();
    chk("rst_ignore_q", out_q, 16'h0000);
    chk("rst_ignore_v", {15'd0, out_valid}, 16'h0000);

    // Release with a capture pending.
    a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    chk("release_q", out_q, 16'h5335);
    chk("release_v", {15'd0, out_valid}, 16'h0001);

    // Random regression subset; the continuous compare checks the registered path.
    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      #2;
      chk("rand_out", out, a | b);
      step();
    end
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/my_or16.md
# my_or16

16-bit bitwise OR for the gate-level arithmetic/logic library. Combinational `OUT = A | B` for immediate use by downstream logic, plus a one-cycle registered copy with a valid qualifier for pipelined consumers. Each bit is built from 2-input NAND cells, consistent with the rest of the gate library, and is instantiated wherever a 16-bit word OR is needed.

## Interface

Single clock domain. Reset is asynchronous and active-low.

Parameters:
- `WIDTH`, default 16: data width. Only 16 is supported and verified.

Ports:
- `CLK`  input  1  rising-edge clock for the registered stage.
- `RST_N`  input  1  asynchronous active-low reset for the registered stage.
- `A`  input  16  operand A.
- `B`  input  16  operand B.
- `IN_VALID`  input  1  capture strobe for the registered stage.
- `OUT`  output  16  combinational `A | B`.
- `OUT_Q`  output  16  registered `A | B`.
- `OUT_VALID`  output  1  high for one cycle after a capture.
- `OUT_ANY`  output  1  combinational reduction OR of `OUT` (1 when any bit is set).

## Operation

Combinational path:
- For every bit i in 0..15, `OUT[i] = A[i] OR B[i]`.
- Each bit is realized as `NAND(NAND(A[i],A[i]), NAND(B[i],B[i]))`, built from a 2-input NAND primitive cell.
- There is no cross-bit dependency and no carry.
- `OUT` does not depend on `CLK`, `RST_N` or `IN_VALID`. It is valid whenever A and B are stable, including while reset is asserted.
- `OUT_ANY` is the OR-tree over `OUT[15:0]`, built from the same OR cells.

Registered path:
- On a rising `CLK` edge with `IN_VALID`=1: `OUT_Q` <= `A | B` and `OUT_VALID` <= 1.
- On a rising `CLK` edge with `IN_VALID`=0: `OUT_Q` holds its value and `OUT_VALID` <= 0.
- No backpressure: the stage accepts a new capture every cycle.

Reset:
- `RST_N`=0 immediately forces `OUT_Q`=16'h0000 and `OUT_VALID`=0, independent of `CLK`.
- While reset is held, captures are ignored.
- After `RST_N` deasserts, the first rising edge with `IN_VALID`=1 captures normally.
- Reset asserted mid-stream discards the held value.

## Timing

- `OUT` and `OUT_ANY`: zero cycles of latency, purely combinational. The path has at most three NAND levels per bit plus the reduction tree for `OUT_ANY`.
- `OUT_Q` and `OUT_VALID`: one cycle of latency. The operands present at edge N appear after edge N.
- Back-to-back captures produce back-to-back valid results.
- The registered outputs must be glitch-free, since they are driven directly from flops.
- Reset values: `OUT_Q`=0 and `OUT_VALID`=0. `OUT` and `OUT_ANY` have no reset value because they follow the inputs.

## Test plan

- Exhaustive combinational sweep:
  - Step A over 16'h0000..16'hFFFF, with B stepped over 16'h0000..16'hFFFF for each A.
  - Allow 50 time units per step.
  - Required response: `OUT == A|B` at every step. Spot checks: A=16'h0000,B=16'h0000 -> 16'h0000; A=16'hFFFF,B=16'h0000 -> 16'hFFFF; A=16'hAAAA,B=16'h5555 -> 16'hFFFF.
  - A reduced random subset is acceptable for regression.
- Reduction output: A=0,B=0 -> `OUT_ANY`=0; A=16'h8000,B=0 -> 1; A=0,B=16'h0001 -> 1.
- Registered capture: A=16'h00F0, B=16'h0F00, `IN_VALID`=1 for one edge -> next cycle `OUT_Q`=16'h0FF0 and `OUT_VALID`=1. The following cycle, with `IN_VALID`=0 -> `OUT_VALID`=0 and `OUT_Q` still 16'h0FF0.
- Back-to-back captures: (16'h0001, 16'h0002) then (16'h1000, 16'h0100) on consecutive edges -> `OUT_Q`=16'h0003 then 16'h1100, with `OUT_VALID` high both cycles.
- Asynchronous reset: with `OUT_Q`=16'hFFFF, drop `RST_N` between edges -> `OUT_Q`=0 and `OUT_VALID`=0 immediately. Meanwhile `OUT` continues to track A|B.
- Reset release: deassert `RST_N` with `IN_VALID`=1, A=16'h1234, B=16'h4321 -> `OUT_Q`=16'h5335 after the first edge.
